// File: rtl/dram_arbiter.sv
// Two-master arbiter for the hxd32 data-RAM port with bounded m1 lock-hold.
// Optional round-robin arbitration is enabled with `define DRAM_ARBITER_RR_EN.
module dram_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wr_data_i,
  input  logic [3:0]      m0_byte_en_i,
  output logic            m0_gnt_o,
  output logic            m0_rd_valid_o,
  output logic [XLEN-1:0] m0_rd_data_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wr_data_i,
  input  logic [3:0]      m1_byte_en_i,
  input  logic            m1_lock_i,
  output logic            m1_gnt_o,
  output logic            m1_rd_valid_o,
  output logic [XLEN-1:0] m1_rd_data_o,
  output logic [XLEN-1:0] dram_rd_addr_o,
  input  logic [XLEN-1:0] dram_rd_data_i,
  output logic [XLEN-1:0] dram_wr_addr_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  output logic [3:0]      dram_wr_byte_en_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] hold_cnt_r;
  logic       rd_pend_r;
  logic       rd_tag_r;
  logic       m1_hold_s;
  logic       m0_win_s;
  logic       m1_win_s;

  // m1 keeps ownership while locked and under the hold budget
  always_comb begin
    m1_hold_s = (state_r == OWN_M1) && m1_lock_i && m1_req_i && (hold_cnt_r < MAX_HOLD_C);
  end

  // Winner selection; nothing is granted while reset is asserted
  always_comb begin
    m0_win_s = 1'b0;
    m1_win_s = 1'b0;
    if (rst_i) begin
      m0_win_s = 1'b0;
      m1_win_s = 1'b0;
    end else if (m1_hold_s) begin
      m1_win_s = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
`ifdef DRAM_ARBITER_RR_EN
      m1_win_s = (state_r == OWN_M0);
      m0_win_s = (state_r != OWN_M0);
`else
      m0_win_s = 1'b1;
`endif
    end else if (m0_req_i) begin
      m0_win_s = 1'b1;
    end else if (m1_req_i) begin
      m1_win_s = 1'b1;
    end else begin
      m0_win_s = 1'b0;
      m1_win_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: last granted master, or IDLE when nobody asks
  always_comb begin
    state_nxt_s = state_r;
    if (m0_win_s) begin
      state_nxt_s = OWN_M0;
    end else if (m1_win_s) begin
      state_nxt_s = OWN_M1;
    end else if (!m0_req_i && !m1_req_i) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Grants and DRAM port mux
  always_comb begin
    m0_gnt_o          = m0_win_s;
    m1_gnt_o          = m1_win_s;
    dram_rd_addr_o    = '0;
    dram_wr_addr_o    = '0;
    dram_wr_data_o    = '0;
    dram_wr_byte_en_o = 4'b0000;
    if (m0_win_s) begin
      dram_rd_addr_o    = m0_addr_i;
      dram_wr_addr_o    = m0_addr_i;
      dram_wr_data_o    = m0_wr_data_i;
      dram_wr_byte_en_o = m0_we_i ? m0_byte_en_i : 4'b0000;
    end else if (m1_win_s) begin
      dram_rd_addr_o    = m1_addr_i;
      dram_wr_addr_o    = m1_addr_i;
      dram_wr_data_o    = m1_wr_data_i;
      dram_wr_byte_en_o = m1_we_i ? m1_byte_en_i : 4'b0000;
    end else begin
      dram_rd_addr_o    = '0;
      dram_wr_addr_o    = '0;
      dram_wr_data_o    = '0;
      dram_wr_byte_en_o = 4'b0000;
    end
  end

  // Hold counter and read-return tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_r <= 8'd0;
      rd_pend_r  <= 1'b0;
      rd_tag_r   <= 1'b0;
    end else begin
      if (m0_win_s || !m0_req_i) begin
        hold_cnt_r <= 8'd0;
      end else if (m1_win_s) begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      rd_pend_r <= (m0_win_s && !m0_we_i) || (m1_win_s && !m1_we_i);
      rd_tag_r  <= m1_win_s;
    end
  end

  // Read data routed to the tagged master only; a pending read is dropped by reset
  always_comb begin
    m0_rd_valid_o = rd_pend_r && !rd_tag_r && !rst_i;
    m1_rd_valid_o = rd_pend_r && rd_tag_r && !rst_i;
    m0_rd_data_o  = m0_rd_valid_o ? dram_rd_data_i : '0;
    m1_rd_data_o  = m1_rd_valid_o ? dram_rd_data_i : '0;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter (default fixed-priority build, MAX_HOLD=4).
module tb_dram_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m0_gnt_o, m0_rd_valid_o;
  logic [31:0] m0_addr_i, m0_wr_data_i, m0_rd_data_o;
  logic [3:0]  m0_byte_en_i;
  logic        m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_rd_valid_o;
  logic [31:0] m1_addr_i, m1_wr_data_i, m1_rd_data_o;
  logic [3:0]  m1_byte_en_i;
  logic [31:0] dram_rd_addr_o, dram_rd_data_i, dram_wr_addr_o, dram_wr_data_o;
  logic [3:0]  dram_wr_byte_en_o;
  int          tests = 0;
  int          failed = 0;

  dram_arbiter #(.XLEN(32), .MAX_HOLD(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_wr_data_i(m0_wr_data_i), .m0_byte_en_i(m0_byte_en_i), .m0_gnt_o(m0_gnt_o),
    .m0_rd_valid_o(m0_rd_valid_o), .m0_rd_data_o(m0_rd_data_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wr_data_i(m1_wr_data_i), .m1_byte_en_i(m1_byte_en_i), .m1_lock_i(m1_lock_i),
    .m1_gnt_o(m1_gnt_o), .m1_rd_valid_o(m1_rd_valid_o), .m1_rd_data_o(m1_rd_data_o),
    .dram_rd_addr_o(dram_rd_addr_o), .dram_rd_data_i(dram_rd_data_i),
    .dram_wr_addr_o(dram_wr_addr_o), .dram_wr_data_o(dram_wr_data_o),
    .dram_wr_byte_en_o(dram_wr_byte_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    m0_req_i = req; m0_we_i = we; m0_addr_i = addr; m0_wr_data_i = data; m0_byte_en_i = be;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input logic lock);
    m1_req_i = req; m1_we_i = we; m1_addr_i = addr; m1_wr_data_i = data; m1_byte_en_i = be;
    m1_lock_i = lock;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #2 later
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    dram_rd_data_i = 32'h0;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    cyc();
    // Requests during reset must not be granted
    drive_m0(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    #2;
    check("rst_m0_gnt", {31'd0, m0_gnt_o}, 32'd0);
    check("rst_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    check("rst_strobe", {28'd0, dram_wr_byte_en_o}, 32'd0);
    check("rst_rd_valid", {30'd0, m1_rd_valid_o, m0_rd_valid_o}, 32'd0);
    check("rst_rd_data", m0_rd_data_o | m1_rd_data_o, 32'd0);

    // m0 single read
    cyc();
    rst_i = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #2;
    check("t1_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    check("t1_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    check("t1_rd_addr", dram_rd_addr_o, 32'h100);
    check("t1_strobe", {28'd0, dram_wr_byte_en_o}, 32'd0);
    cyc();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dram_rd_data_i = 32'hDEAD_BEEF;
    #2;
    check("t1_m0_valid", {31'd0, m0_rd_valid_o}, 32'd1);
    check("t1_m0_data", m0_rd_data_o, 32'hDEAD_BEEF);
    check("t1_m1_valid", {31'd0, m1_rd_valid_o}, 32'd0);
    check("t1_m1_data", m1_rd_data_o, 32'd0);
    check("t1_gnt_idle", {30'd0, m1_gnt_o, m0_gnt_o}, 32'd0);
    check("t1_rd_addr_idle", dram_rd_addr_o, 32'd0);
    cyc();
    #2;
    check("t1_valid_pulse", {31'd0, m0_rd_valid_o}, 32'd0);

    // Simultaneous reads: m0 first, then m1
    cyc();
    drive_m0(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
    #2;
    check("t2_c0_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    check("t2_c0_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    check("t2_c0_rd_addr", dram_rd_addr_o, 32'h200);
    cyc();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dram_rd_data_i = 32'h1111_0000;
    #2;
    check("t2_c1_m1_gnt", {31'd0, m1_gnt_o}, 32'd1);
    check("t2_c1_rd_addr", dram_rd_addr_o, 32'h300);
    check("t2_c1_m0_data", m0_rd_data_o, 32'h1111_0000);
    check("t2_c1_m1_valid", {31'd0, m1_rd_valid_o}, 32'd0);
    cyc();
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    dram_rd_data_i = 32'h2222_0000;
    #2;
    check("t2_c2_m1_valid", {31'd0, m1_rd_valid_o}, 32'd1);
    check("t2_c2_m1_data", m1_rd_data_o, 32'h2222_0000);
    check("t2_c2_m0_valid", {31'd0, m0_rd_valid_o}, 32'd0);
    check("t2_c2_m0_data", m0_rd_data_o, 32'd0);

    // Lock hold: m1 owns, then m0 waits for exactly MAX_HOLD=4 m1 grants
    cyc();
    drive_m1(1'b1, 1'b1, 32'h40, 32'hC0DE_0000, 4'hF, 1'b1);
    #2;
    check("t3_setup_m1_gnt", {31'd0, m1_gnt_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_m0(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
      drive_m1(1'b1, 1'b1, 32'h44 + 32'(4 * i), 32'hC0DE_0001 + 32'(i), 4'hF, 1'b1);
      #2;
      check($sformatf("t3_hold%0d_m1_gnt", i), {31'd0, m1_gnt_o}, 32'd1);
      check($sformatf("t3_hold%0d_m0_gnt", i), {31'd0, m0_gnt_o}, 32'd0);
    end
    cyc();
    drive_m1(1'b1, 1'b1, 32'h54, 32'hC0DE_0005, 4'hF, 1'b1);
    #2;
    check("t3_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    check("t3_m1_blocked", {31'd0, m1_gnt_o}, 32'd0);
    check("t3_m0_rd_addr", dram_rd_addr_o, 32'h500);
    check("t3_m0_no_strobe", {28'd0, dram_wr_byte_en_o}, 32'd0);
    cyc();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dram_rd_data_i = 32'h5555_AAAA;
    #2;
    check("t3_m1_resume", {31'd0, m1_gnt_o}, 32'd1);
    check("t3_m1_wr_addr", dram_wr_addr_o, 32'h54);
    check("t3_m1_wr_data", dram_wr_data_o, 32'hC0DE_0005);
    check("t3_m1_strobe", {28'd0, dram_wr_byte_en_o}, 32'hF);
    check("t3_m0_valid", {31'd0, m0_rd_valid_o}, 32'd1);
    check("t3_m0_data", m0_rd_data_o, 32'h5555_AAAA);

    // Partial-strobe m1 write, no read return afterwards
    cyc();
    drive_m1(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b0);
    #2;
    check("t4_m1_gnt", {31'd0, m1_gnt_o}, 32'd1);
    check("t4_strobe", {28'd0, dram_wr_byte_en_o}, 32'h3);
    check("t4_wr_addr", dram_wr_addr_o, 32'h20);
    check("t4_wr_data", dram_wr_data_o, 32'h1234_5678);
    check("t4_no_valid_prev_write", {31'd0, m1_rd_valid_o}, 32'd0);
    cyc();
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #2;
    check("t4_no_valid", {30'd0, m1_rd_valid_o, m0_rd_valid_o}, 32'd0);

    // Alternating single-master reads, one per cycle
    for (int k = 0; k < 5; k++) begin
      cyc();
      drive_m0((k < 4) && (k % 2 == 0), 1'b0, 32'h600 + 32'(k), 32'h0, 4'h0);
      drive_m1((k < 4) && (k % 2 == 1), 1'b0, 32'h700 + 32'(k), 32'h0, 4'h0, 1'b0);
      dram_rd_data_i = 32'hA000_0000 + 32'(k);
      #2;
      if (k < 4) begin
        check($sformatf("t5_k%0d_m0_gnt", k), {31'd0, m0_gnt_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
        check($sformatf("t5_k%0d_m1_gnt", k), {31'd0, m1_gnt_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (k > 0) begin
        check($sformatf("t5_k%0d_m0_valid", k), {31'd0, m0_rd_valid_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
        check($sformatf("t5_k%0d_m1_valid", k), {31'd0, m1_rd_valid_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
        check($sformatf("t5_k%0d_m0_data", k), m0_rd_data_o,
              (k % 2 == 1) ? 32'hA000_0000 + 32'(k) : 32'd0);
        check($sformatf("t5_k%0d_m1_data", k), m1_rd_data_o,
              (k % 2 == 0) ? 32'hA000_0000 + 32'(k) : 32'd0);
      end
    end

    // Zero-strobe write is granted but writes nothing
    cyc();
    drive_m0(1'b1, 1'b1, 32'h80, 32'hFACE_FACE, 4'h0);
    #2;
    check("t6_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    check("t6_strobe", {28'd0, dram_wr_byte_en_o}, 32'd0);
    cyc();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    check("t6_no_valid", {31'd0, m0_rd_valid_o}, 32'd0);

    // Reset with a read pending drops the read
    cyc();
    drive_m0(1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
    #2;
    check("t7_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    cyc();
    rst_i = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    dram_rd_data_i = 32'hBAD0_BAD0;
    #2;
    check("t7_rst_valid", {31'd0, m0_rd_valid_o}, 32'd0);
    check("t7_rst_data", m0_rd_data_o, 32'd0);
    check("t7_rst_addr", dram_rd_addr_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    #2;
    check("t7_post_valid", {30'd0, m1_rd_valid_o, m0_rd_valid_o}, 32'd0);
    check("t7_post_data", m0_rd_data_o, 32'd0);
    cyc();
    drive_m1(1'b1, 1'b0, 32'hA00, 32'h0, 4'h0, 1'b0);
    #2;
    check("t7_m1_gnt", {31'd0, m1_gnt_o}, 32'd1);
    check("t7_m1_rd_addr", dram_rd_addr_o, 32'hA00);
    cyc();
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    dram_rd_data_i = 32'h0BAD_F00D;
    #2;
    check("t7_m1_valid", {31'd0, m1_rd_valid_o}, 32'd1);
    check("t7_m1_data", m1_rd_data_o, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
